// File: rtl/regbank_writeback_queue.sv
// In-order write-back queue feeding the register bank write port.
// Pending entries are forwarded to both read ports, and the youngest matching entry wins.
module regbank_writeback_queue #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 4,
    parameter int DROP_X0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              wb_hold,
    output logic [ADDR_W-1:0] register3,
    output logic [DATA_W-1:0] datain,
    output logic              regwrite,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_drop_rd;
    logic              w_store;
    logic              w_retire;
    logic              w_nonempty;
    logic [DATA_W:0]   w_fwd1;
    logic [DATA_W:0]   w_fwd2;

    // Walk from oldest to youngest so a later (younger) match overrides an earlier one.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] rs);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_rd_ptr + PTR_W'(k);
            if (r_valid[idx] && (r_rd[idx] == rs) && !((DROP_X0 != 0) && (rs == '0))) begin
                res = {1'b1, r_data[idx]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_nonempty = (r_count != '0);
    assign w_drop_rd  = (DROP_X0 != 0) && (wb_rd == '0);
    assign wb_ready   = (r_count != CNT_W'(DEPTH));
    assign w_store    = wb_valid && wb_ready && !w_drop_rd;
    assign w_retire   = w_nonempty && !wb_hold;
    assign regwrite   = w_retire;
    assign register3  = w_nonempty ? r_rd[r_rd_ptr]   : '0;
    assign datain     = w_nonempty ? r_data[r_rd_ptr] : '0;

    // Forwarding search for both bank read ports.
    always_comb begin
        w_fwd1 = fwd_lookup(rs1);
        w_fwd2 = fwd_lookup(rs2);
    end

    assign fwd1_hit  = w_fwd1[DATA_W];
    assign fwd1_data = w_fwd1[DATA_W-1:0];
    assign fwd2_hit  = w_fwd2[DATA_W];
    assign fwd2_data = w_fwd2[DATA_W-1:0];

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_retire) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            // Store is blocked when full and retire is gated when empty, so the two slots never coincide.
            if (w_store) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_rd[r_wr_ptr]    <= wb_rd;
                r_data[r_wr_ptr]  <= wb_data;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            case ({w_store, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_writeback_queue.sv
// Self-checking bench for regbank_writeback_queue: table vectors, corner sequences,
// and random traffic against a queue-based reference model with a shadow register bank.
module tb_regbank_writeback_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [63:0] wb_data = 64'd0;
    logic        wb_ready;
    logic        wb_hold = 1'b0;
    logic [4:0]  register3;
    logic [63:0] datain;
    logic        regwrite;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic        fwd1_hit;
    logic [63:0] fwd1_data;
    logic        fwd2_hit;
    logic [63:0] fwd2_data;

    regbank_writeback_queue dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .wb_hold(wb_hold), .register3(register3), .datain(datain), .regwrite(regwrite),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    // Register bank driven only by the DUT write port.
    logic [63:0] dut_bank [32] = '{default: 64'h0};
    always @(posedge clk) begin
        if (regwrite) dut_bank[register3] <= datain;
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } entry_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        hold;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ready;
        logic        e_rw;
        logic [4:0]  e_r3;
        logic [63:0] e_din;
        logic        e_f1hit;
        logic [63:0] e_f1d;
        logic        e_f2hit;
        logic [63:0] e_f2d;
    } vec_t;

    entry_t      model_q[$];
    logic [63:0] model_bank [32] = '{default: 64'h0};
    int          n_vec = 0;
    int          n_bad = 0;
    localparam int DEPTH = 4;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [63:0] d,
                                input logic h, input logic [4:0] a, input logic [4:0] b);
        vec_t r;
        r = '0;
        r.valid = v; r.rd = rd; r.data = d; r.hold = h; r.rs1 = a; r.rs2 = b;
        return r;
    endfunction

    // Youngest pending write to register rs, per the queue contents (x0 never matches).
    task automatic model_fwd(input logic [4:0] rs, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = 64'd0;
        if (rs != 5'd0) begin
            foreach (model_q[i]) begin
                if (model_q[i].rd == rs) begin
                    hit = 1'b1;
                    d   = model_q[i].data;
                end
            end
        end
    endtask

    // One clock: drive inputs, check at negedge, then advance the model across the edge.
    task automatic cycle(input vec_t v, input bit use_tbl);
        logic        e_ready, e_rw, h1, h2;
        logic [4:0]  e_r3;
        logic [63:0] e_din, d1, d2;
        wb_valid = v.valid; wb_rd = v.rd; wb_data = v.data; wb_hold = v.hold;
        rs1 = v.rs1; rs2 = v.rs2;
        @(negedge clk);
        e_ready = (model_q.size() != DEPTH);
        e_rw    = (model_q.size() != 0) && !v.hold;
        e_r3    = (model_q.size() != 0) ? model_q[0].rd : 5'd0;
        e_din   = (model_q.size() != 0) ? model_q[0].data : 64'd0;
        model_fwd(v.rs1, h1, d1);
        model_fwd(v.rs2, h2, d2);
        chk("wb_ready",  {63'd0, wb_ready},  {63'd0, e_ready});
        chk("regwrite",  {63'd0, regwrite},  {63'd0, e_rw});
        chk("register3", {59'd0, register3}, {59'd0, e_r3});
        chk("datain",    datain,             e_din);
        chk("fwd1_hit",  {63'd0, fwd1_hit},  {63'd0, h1});
        chk("fwd1_data", fwd1_data,          d1);
        chk("fwd2_hit",  {63'd0, fwd2_hit},  {63'd0, h2});
        chk("fwd2_data", fwd2_data,          d2);
        if (use_tbl) begin
            chk("tbl_ready", {63'd0, wb_ready},  {63'd0, v.e_ready});
            chk("tbl_rw",    {63'd0, regwrite},  {63'd0, v.e_rw});
            chk("tbl_r3",    {59'd0, register3}, {59'd0, v.e_r3});
            chk("tbl_din",   datain,             v.e_din);
            chk("tbl_f1hit", {63'd0, fwd1_hit},  {63'd0, v.e_f1hit});
            chk("tbl_f1d",   fwd1_data,          v.e_f1d);
            chk("tbl_f2hit", {63'd0, fwd2_hit},  {63'd0, v.e_f2hit});
            chk("tbl_f2d",   fwd2_data,          v.e_f2d);
        end
        @(posedge clk);
        if (e_rw) begin
            model_bank[model_q[0].rd] = model_q[0].data;
            void'(model_q.pop_front());
        end
        if (v.valid && e_ready && (v.rd != 5'd0)) model_q.push_back('{rd: v.rd, data: v.data});
        #1;
    endtask

    vec_t tbl [11];
    vec_t v;

    initial begin
        //          vld   rd     data            hold  rs1    rs2    rdy   rw    r3     din             f1h   f1d      f2h   f2d
        tbl[0]  = '{1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0,          1'b0, 64'd0,          1'b0, 64'd0};
        tbl[1]  = '{1'b0, 5'd0, 64'd0,         1'b0, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b1, 64'hDEAD_BEEF, 1'b0, 64'd0};
        tbl[2]  = '{1'b0, 5'd0, 64'd0,         1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0,          1'b0, 64'd0,          1'b0, 64'd0};
        tbl[3]  = '{1'b1, 5'd7, 64'd1,         1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0,          1'b0, 64'd0,          1'b0, 64'd0};
        tbl[4]  = '{1'b1, 5'd7, 64'd2,         1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 64'd1,          1'b1, 64'd1,          1'b0, 64'd0};
        tbl[5]  = '{1'b0, 5'd0, 64'd0,         1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 64'd1,          1'b1, 64'd2,          1'b1, 64'd2};
        tbl[6]  = '{1'b0, 5'd0, 64'd0,         1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'd1,          1'b1, 64'd2,          1'b0, 64'd0};
        tbl[7]  = '{1'b0, 5'd0, 64'd0,         1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 64'd2,          1'b1, 64'd2,          1'b0, 64'd0};
        tbl[8]  = '{1'b0, 5'd0, 64'd0,         1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0,          1'b0, 64'd0,          1'b0, 64'd0};
        tbl[9]  = '{1'b1, 5'd0, 64'd9,         1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0,          1'b0, 64'd0,          1'b0, 64'd0};
        tbl[10] = '{1'b0, 5'd0, 64'd0,         1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 64'd0,          1'b0, 64'd0,          1'b0, 64'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, wb_ready}, 64'd1);
        chk("rst_rw",    {63'd0, regwrite}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) cycle(tbl[i], 1'b1);
        chk("bank5", dut_bank[5], 64'hDEAD_BEEF);
        chk("bank7", dut_bank[7], 64'd2);
        chk("bank0", dut_bank[0], 64'd0);

        // Fill with hold, offer a fifth request, then release the hold.
        for (int i = 1; i <= 4; i++) cycle(mk(1'b1, 5'(i + 8), 64'(i * 17), 1'b1, 5'd9, 5'd12), 1'b0);
        cycle(mk(1'b1, 5'd13, 64'h55, 1'b1, 5'd13, 5'd12), 1'b0);
        chk("full_ready", {63'd0, wb_ready}, 64'd0);
        for (int i = 0; i < 6; i++) cycle(mk(1'b1, 5'd13, 64'h55, 1'b0, 5'd13, 5'd10), 1'b0);
        cycle(mk(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0), 1'b0);
        chk("fill_bank12", dut_bank[12], 64'd68);
        chk("fill_bank13", dut_bank[13], 64'h55);

        // Simultaneous enqueue and retire at occupancy two.
        cycle(mk(1'b1, 5'd20, 64'hA0, 1'b1, 5'd20, 5'd21), 1'b0);
        cycle(mk(1'b1, 5'd21, 64'hA1, 1'b1, 5'd20, 5'd21), 1'b0);
        cycle(mk(1'b1, 5'd22, 64'hA2, 1'b0, 5'd22, 5'd21), 1'b0);
        cycle(mk(1'b0, 5'd0,  64'd0,  1'b1, 5'd22, 5'd20), 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++)
            cycle(mk(1'b1, 5'(16 + (i % 5)), 64'(1000 + i), 1'b0, 5'(16 + (i % 5)), 5'd18), 1'b0);
        for (int i = 0; i < 4; i++) cycle(mk(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0), 1'b0);

        // Reset mid-burst with three entries pending.
        for (int i = 0; i < 3; i++) cycle(mk(1'b1, 5'(24 + i), 64'(64'hBAD0 + i), 1'b1, 5'd24, 5'd26), 1'b0);
        wb_valid = 1'b0; wb_hold = 1'b0; rs1 = 5'd24; rs2 = 5'd26;
        #1;
        chk("pre_rst_rw", {63'd0, regwrite}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rw",    {63'd0, regwrite},  64'd0);
        chk("mid_rst_ready", {63'd0, wb_ready},  64'd1);
        chk("mid_rst_r3",    {59'd0, register3}, 64'd0);
        chk("mid_rst_din",   datain,             64'd0);
        chk("mid_rst_f1",    {63'd0, fwd1_hit},  64'd0);
        chk("mid_rst_f2",    {63'd0, fwd2_hit},  64'd0);
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle(mk(1'b0, 5'd0, 64'd0, 1'b0, 5'd24, 5'd25), 1'b0);
        for (int i = 24; i < 27; i++) chk("rst_lost_bank", dut_bank[i], 64'd0);

        // Random traffic with frequent register collisions.
        for (int i = 0; i < 400; i++) begin
            v = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                   1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle(v, 1'b0);
        end
        for (int i = 0; i < 8; i++) cycle(mk(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0), 1'b0);
        for (int i = 0; i < 32; i++) chk("final_bank", dut_bank[i], model_bank[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
